input_sequencer: RTL and testbench

INPUT_SEQUENCER -- requirements
Module: input_sequencer

---
 rtl/input_sequencer_if.sv | 30 +++
 rtl/input_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_input_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/input_sequencer_if.sv
// ----------------------------------------------------------------------------
// input_sequencer_if
// Purpose : groups the streaming handshake of input_sequencer.
//   in_valid / in_data        : decoded word strobe from the TAP word decoder
//   out_ready                 : downstream accepts the current head word
//   out_valid/out_data/out_last : FIFO head presented to downstream
// Modports:
//   master : the environment (drives words in, drives out_ready)
//   slave  : the sequencer (receives words, presents FIFO head)
// ----------------------------------------------------------------------------
interface input_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last
    );
endinterface

// File: rtl/input_sequencer.sv
// ----------------------------------------------------------------------------
// input_sequencer
// Purpose : collects decoded words into a one-entry pending register followed
//           by a {last, data} FIFO. The word preceding the end marker is
//           tagged last; the marker itself is never stored.
// Ports:
//   tck              : clock, all updates on rising edge
//   rst_n            : asynchronous active-low reset
//   test_logic_reset : synchronous active-high clear, same effect as reset
//   bus (slave)      : in_valid/in_data in, out_ready in, out_valid/out_data/
//                      out_last out (FIFO head)
//   busy             : state is RUN or DRAIN
//   done             : state is DONE
//   overflow         : sticky, a push was dropped on a full FIFO
//   word_count       : accepted pushes, saturating
// ----------------------------------------------------------------------------
module input_sequencer #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [DATA_WIDTH-1:0] END_MARKER  = '1,
    parameter int                    COUNT_WIDTH = 16
) (
    input  logic                   tck,
    input  logic                   rst_n,
    input  logic                   test_logic_reset,
    input_sequencer_if.slave       bus,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] word_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [AW:0]          ONE_ENTRY = {{AW{1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pend_data;
    logic                  r_pend_vld;
    logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic                  r_overflow;
    logic [COUNT_WIDTH-1:0] r_word_count;

    logic        w_empty;
    logic        w_full;
    logic [AW:0] w_count;
    logic        w_pop;
    logic        w_is_marker;
    logic        w_push_req;
    logic        w_push_last;
    logic        w_push_ok;
    logic        w_drop;
    logic        w_load_pend;
    logic        w_clear_pend;

    // Full when the pointers share an index but differ in the wrap bit.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_pop   = !w_empty && bus.out_ready;
    assign w_is_marker = (bus.in_data == END_MARKER);

    // A same-cycle pop frees a slot, so a push against a full FIFO still fits.
    assign w_push_ok = w_push_req && (!w_full || w_pop);
    assign w_drop    = w_push_req && w_full && !w_pop;

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = r_mem[r_rd_ptr[AW-1:0]][DATA_WIDTH-1:0];
    assign bus.out_last  = r_mem[r_rd_ptr[AW-1:0]][DATA_WIDTH];

    assign busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done       = (r_state == ST_DONE);
    assign overflow   = r_overflow;
    assign word_count = r_word_count;

    // Next-state, push and pending-register control decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_push_req   = 1'b0;
        w_push_last  = 1'b0;
        w_load_pend  = 1'b0;
        w_clear_pend = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (w_is_marker) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_load_pend = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.in_valid) begin
                    w_push_req = r_pend_vld;
                    if (w_is_marker) begin
                        w_push_last  = 1'b1;
                        w_clear_pend = 1'b1;
                        w_state_nxt  = ST_DRAIN;
                    end else begin
                        w_load_pend = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // An already-empty FIFO (last word dropped and drained) also ends DRAIN.
                if (w_empty || (w_pop && (w_count == ONE_ENTRY))) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control state, pending register, pointers and status counters.
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pend_data  <= {DATA_WIDTH{1'b0}};
            r_pend_vld   <= 1'b0;
            r_wr_ptr     <= {(AW+1){1'b0}};
            r_rd_ptr     <= {(AW+1){1'b0}};
            r_overflow   <= 1'b0;
            r_word_count <= {COUNT_WIDTH{1'b0}};
        end else if (test_logic_reset) begin
            r_state      <= ST_IDLE;
            r_pend_data  <= {DATA_WIDTH{1'b0}};
            r_pend_vld   <= 1'b0;
            r_wr_ptr     <= {(AW+1){1'b0}};
            r_rd_ptr     <= {(AW+1){1'b0}};
            r_overflow   <= 1'b0;
            r_word_count <= {COUNT_WIDTH{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_load_pend) begin
                r_pend_data <= bus.in_data;
                r_pend_vld  <= 1'b1;
            end else if (w_clear_pend) begin
                r_pend_vld  <= 1'b0;
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ONE_ENTRY;
                if (r_word_count != CNT_MAX) begin
                    r_word_count <= r_word_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ONE_ENTRY;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge tck) begin
        if (w_push_ok && !test_logic_reset) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_push_last, r_pend_data};
        end
    end
endmodule

// File: tb/tb_input_sequencer.sv
module tb_input_sequencer;
    localparam int DW = 16;
    localparam int CW = 16;

    logic          tck;
    logic          rst_n;
    logic          test_logic_reset;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [CW-1:0] word_count;

    int checks = 0;
    int errors = 0;

    input_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    input_sequencer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4),
        .END_MARKER (16'hFFFF),
        .COUNT_WIDTH(CW)
    ) dut (
        .tck             (tck),
        .rst_n           (rst_n),
        .test_logic_reset(test_logic_reset),
        .bus             (bus.slave),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow),
        .word_count      (word_count)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; sampling point is 1 time unit after the edge.
    task automatic step();
        @(posedge tck);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic tlr_pulse();
        test_logic_reset = 1'b1;
        step();
        test_logic_reset = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        test_logic_reset = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_data      = 16'h0000;
        bus.out_ready    = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        rst_n = 1'b1;

        // Basic stream 1,2,3,marker with out_ready held high.
        bus.out_ready = 1'b1;
        send(16'h0001);
        chk("s1_busy", 32'(busy), 32'd1);
        chk("s1_out_valid_lat", 32'(bus.out_valid), 32'd0);
        send(16'h0002);
        chk("s1_head1", 32'(bus.out_data), 32'h1);
        chk("s1_last1", 32'(bus.out_last), 32'd0);
        send(16'h0003);
        chk("s1_head2", 32'(bus.out_data), 32'h2);
        chk("s1_last2", 32'(bus.out_last), 32'd0);
        send(16'hFFFF);
        chk("s1_head3", 32'(bus.out_data), 32'h3);
        chk("s1_last3", 32'(bus.out_last), 32'd1);
        chk("s1_drain_busy", 32'(busy), 32'd1);
        chk("s1_drain_done", 32'(done), 32'd0);
        step();
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_busy_off", 32'(busy), 32'd0);
        chk("s1_empty", 32'(bus.out_valid), 32'd0);
        chk("s1_word_count", 32'(word_count), 32'd3);
        send(16'h0009);
        chk("done_ignores_in", 32'(bus.out_valid), 32'd0);
        chk("done_hold", 32'(done), 32'd1);

        // Marker as the very first word.
        tlr_pulse();
        chk("tlr_done_clr", 32'(done), 32'd0);
        chk("tlr_wc_clr", 32'(word_count), 32'd0);
        send(16'hFFFF);
        chk("m1_done", 32'(done), 32'd1);
        chk("m1_out_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("m1_out_valid2", 32'(bus.out_valid), 32'd0);
        chk("m1_word_count", 32'(word_count), 32'd0);

        // test_logic_reset wins over a coincident in_valid, then a new word starts RUN.
        bus.in_valid     = 1'b1;
        bus.in_data      = 16'h0007;
        test_logic_reset = 1'b1;
        step();
        test_logic_reset = 1'b0;
        bus.in_valid     = 1'b0;
        chk("tlr_prio_busy", 32'(busy), 32'd0);
        chk("tlr_prio_done", 32'(done), 32'd0);
        send(16'h0005);
        chk("tlr_run_busy", 32'(busy), 32'd1);
        chk("tlr_run_done", 32'(done), 32'd0);

        // Overflow: six words, no downstream acceptance.
        tlr_pulse();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(16'(16'h0010 + i));
        chk("ov_no_ov_yet", 32'(overflow), 32'd0);
        chk("ov_wc4", 32'(word_count), 32'd4);
        send(16'h0015);
        chk("ov_set", 32'(overflow), 32'd1);
        chk("ov_wc_hold", 32'(word_count), 32'd4);
        step();
        step();
        chk("ov_head_stable", 32'(bus.out_data), 32'h10);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ov_drain", 32'(bus.out_data), 32'(16'h0010 + i));
            step();
        end
        chk("ov_drained", 32'(bus.out_valid), 32'd0);
        chk("ov_sticky", 32'(overflow), 32'd1);

        // Push into a full FIFO with a same-cycle pop.
        tlr_pulse();
        chk("tlr_ov_clr", 32'(overflow), 32'd0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(16'(16'h0020 + i));
        bus.out_ready = 1'b1;
        send(16'h0025);
        chk("fp_no_ov", 32'(overflow), 32'd0);
        chk("fp_wc5", 32'(word_count), 32'd5);
        for (int i = 1; i < 5; i++) begin
            chk("fp_drain", 32'(bus.out_data), 32'(16'h0020 + i));
            step();
        end
        chk("fp_occ4_empty", 32'(bus.out_valid), 32'd0);
        send(16'hFFFF);
        chk("fp_last_data", 32'(bus.out_data), 32'h25);
        chk("fp_last_flag", 32'(bus.out_last), 32'd1);
        step();
        chk("fp_done", 32'(done), 32'd1);
        chk("fp_wc6", 32'(word_count), 32'd6);

        // Asynchronous reset mid-stream with two words in the FIFO.
        tlr_pulse();
        bus.out_ready = 1'b0;
        send(16'h0030);
        send(16'h0031);
        send(16'h0032);
        chk("ar_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("ar_pre_wc", 32'(word_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_wc", 32'(word_count), 32'd0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(16'h0040);
        send(16'hFFFF);
        chk("ar_new_data", 32'(bus.out_data), 32'h40);
        chk("ar_new_last", 32'(bus.out_last), 32'd1);
        step();
        chk("ar_new_done", 32'(done), 32'd1);
        chk("ar_new_wc", 32'(word_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
